// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, falling-edge start
// detection, mid-bit sampling, LSB-first byte assembly, and a
// valid/acknowledge output handshake with framing and overrun flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       Serial_In,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // Last count of the half-bit wait (start bit) and of a full bit period.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            sync1_q;
  logic            sync2_q;
  logic            sync2_dly_q;
  logic            fall_edge;

  // Synchronise the asynchronous line; idle-high reset so no false edge.
  always_ff @(posedge Clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync2_dly_q <= 1'b1;
    end else begin
      sync1_q     <= Serial_In;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
    end
  end

  // A start edge needs the line to have been high; a held-low line never re-arms.
  assign fall_edge = sync2_dly_q & ~sync2_q;

  // Next-state and output-register logic for the receive FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    // An acknowledge drops the valid flag; a new good frame below overrides it.
    rx_valid_d  = rx_valid_q & ~rx_ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (fall_edge) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // Line back high at mid-start means it was only a glitch.
          state_d   = sync2_q ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync2_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            // Unread byte being replaced, unless the consumer takes it right now.
            overrun_d  = rx_valid_q & ~rx_ack;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (CLKS_PER_BIT = 16).
// Sent frames push their expected completion into a scoreboard; every
// cycle the outputs are compared against a small output-level model.
module tb_uart_rx;

  logic       Clk;
  logic       rst;
  logic       Serial_In;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .Clk       (Clk),
    .rst       (rst),
    .Serial_In (Serial_In),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         s_cyc;
    logic [7:0] data;
    bit         good;
    int         ack_dly;
  } ev_t;

  ev_t        sb[$];
  int         cyc;
  int         ack_at;
  int         n_vec;
  int         n_err;
  logic       model_valid;
  logic [7:0] model_data;
  logic       exp_ferr;
  logic       exp_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, update the model, compare outputs.
  task automatic tick();
    logic ack_s;
    logic rst_s;
    ev_t  ev;
    ack_s = rx_ack;
    rst_s = rst;
    @(posedge Clk);
    #1;
    cyc++;
    rx_ack   = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (rst_s) begin
      model_valid = 1'b0;
      model_data  = 8'h00;
    end else if (sb.size() > 0 && sb[0].s_cyc == cyc) begin
      ev = sb.pop_front();
      if (ev.good) begin
        exp_ovr     = model_valid && !ack_s;
        model_valid = 1'b1;
        model_data  = ev.data;
        if (ev.ack_dly >= 0) ack_at = cyc + ev.ack_dly;
      end else begin
        exp_ferr = 1'b1;
        if (ack_s) model_valid = 1'b0;
      end
    end else if (ack_s) begin
      model_valid = 1'b0;
    end
    chk("outputs", {21'd0, rx_valid, frame_err, overrun, rx_data},
                   {21'd0, model_valid, exp_ferr, exp_ovr, model_data});
    if (cyc == ack_at) rx_ack = 1'b1;
  endtask

  // Send one frame; start edge driven right after the current tick n,
  // so E = n+3 and the stop sample lands at S = n+155.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int idle,
                            input int ack_dly, input bit ack_at_s, input int rst_at);
    ev_t        ev;
    int         n;
    logic [9:0] bits;
    if (idle > 0) begin
      Serial_In = 1'b1;
      repeat (idle) tick();
    end
    n          = cyc;
    bits       = {stop_bit, data, 1'b0};
    ev.s_cyc   = n + 155;
    ev.data    = data;
    ev.good    = stop_bit;
    ev.ack_dly = ack_dly;
    sb.push_back(ev);
    if (ack_at_s) ack_at = n + 154;
    for (int k = 0; k < 160; k++) begin
      Serial_In = bits[4'(k / 16)];
      if (k == rst_at) begin
        rst       = 1'b1;
        Serial_In = 1'b1;
        void'(sb.pop_back());
        tick();
        chk("busy_after_rst", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        break;
      end
      tick();
      if (cyc == n + 2)   chk("busy_before_E", {31'd0, busy}, 32'd0);
      if (cyc == n + 3)   chk("busy_at_E", {31'd0, busy}, 32'd1);
      if (cyc == n + 154) chk("busy_before_S", {31'd0, busy}, 32'd1);
      if (cyc == n + 155) chk("busy_after_S", {31'd0, busy}, 32'd0);
    end
  endtask

  // Short low pulse on an idle line; must be rejected at E+8.
  task automatic send_glitch(input int len);
    int n;
    n = cyc;
    for (int k = 0; k < 20; k++) begin
      Serial_In = (k < len) ? 1'b0 : 1'b1;
      tick();
      if (cyc == n + 3)  chk("glitch_busy_E", {31'd0, busy}, 32'd1);
      if (cyc == n + 10) chk("glitch_busy_E7", {31'd0, busy}, 32'd1);
      if (cyc == n + 11) chk("glitch_idle_E8", {31'd0, busy}, 32'd0);
    end
  endtask

  // Directed sequence.
  initial begin
    cyc         = 0;
    ack_at      = -1;
    n_vec       = 0;
    n_err       = 0;
    model_valid = 1'b0;
    model_data  = 8'h00;
    exp_ferr    = 1'b0;
    exp_ovr     = 1'b0;
    rst         = 1'b1;
    Serial_In   = 1'b1;
    rx_ack      = 1'b0;

    repeat (3) tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Single frame, acked immediately after valid.
    send_frame(8'hA5, 1'b1, 0, 0, 1'b0, -1);
    repeat (4) tick();

    // Back-to-back frames, each acked within 4 cycles.
    send_frame(8'h00, 1'b1, 4, 2, 1'b0, -1);
    send_frame(8'hFF, 1'b1, 0, 3, 1'b0, -1);
    repeat (10) tick();

    // Glitch rejection, then a normal frame.
    send_glitch(5);
    send_frame(8'h3C, 1'b1, 10, 1, 1'b0, -1);
    repeat (6) tick();

    // Ack with nothing valid is ignored.
    rx_ack = 1'b1;
    tick();
    tick();

    // Framing error, line held low afterwards (break).
    send_frame(8'h5A, 1'b0, 4, -1, 1'b0, -1);
    repeat (100) tick();
    chk("break_busy", {31'd0, busy}, 32'd0);

    // Overrun: two unacked frames.
    send_frame(8'h11, 1'b1, 4, -1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 4, -1, 1'b0, -1);
    rx_ack = 1'b1;
    repeat (3) tick();

    // Same again with ack exactly at the second stop sample.
    send_frame(8'h11, 1'b1, 4, -1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 4, -1, 1'b1, -1);
    repeat (2) tick();
    rx_ack = 1'b1;
    repeat (3) tick();

    // Reset in the middle of data bit 4, then a fresh frame.
    send_frame(8'hC3, 1'b1, 4, -1, 1'b0, 88);
    send_frame(8'h81, 1'b1, 20, 0, 1'b0, -1);
    repeat (10) tick();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
